// File: rtl/bolt_pkg.sv
// Shared definitions for the fetch stage and the control decoder.
//   XLEN           : PC / address width
//   *_TYPE         : major opcode encodings that decode recognises
//   fetch_state_e  : fetch FSM states
//   fetch_entry_t  : one buffered fetch result {pc, instr}
package bolt_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] I_TYPEL = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] SB_TYPE = 7'b1100011;
  localparam logic [6:0] U_TYPE  = 7'b0110111;
  localparam logic [6:0] UJ_TYPE = 7'b1101111;

  // RUN: nothing outstanding, WAIT: one granted read outstanding,
  // KILL: the outstanding read belongs to a flushed path and is dropped.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions.
//   clk, rst_n : clock and asynchronous active-low reset
//   push_i     : write wdata_i (caller guarantees not full unless popping)
//   pop_i      : drop the head entry (ignored when empty)
//   clear_i    : empty the FIFO; wins over push and pop
//   wdata_i    : entry to write
//   rdata_o    : head entry (meaningless when empty)
//   count_o    : number of valid entries
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
module fetch_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [63:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  entry_t                 wdata_i,
  output entry_t                 rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_eff;
  logic            pop_eff;

  assign push_eff = push_i && !clear_i;
  assign pop_eff  = pop_i && !clear_i && (count_q != '0);

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Storage needs no reset: nothing reads it until count_q says it is valid.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the control decoder.
//   clk, rst_n     : clock and asynchronous active-low reset
//   redirect_i     : taken branch/jump, flushes all fetch state
//   redirect_pc_i  : redirect target, low two bits ignored
//   imem_req_o     : read request, held with stable address until granted
//   imem_addr_o    : word address of the request (current PC)
//   imem_gnt_i     : memory accepted the request
//   imem_rvalid_i  : read data valid, in order, at least one cycle after grant
//   imem_rdata_i   : instruction word
//   id_valid_o     : buffered instruction available to decode
//   id_ready_i     : decode accepts the presented instruction
//   id_instr_o     : instruction word
//   id_pc_o        : PC of id_instr_o
//   id_op_o        : opcode field  [6:0]
//   id_fun3_o      : funct3 field  [14:12]
//   id_fun7_o      : funct7 field  [31:25]
// XLEN comes from bolt_pkg so the buffered entries match what control expects.
module fetch_stage
  import bolt_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [6:0]      id_op_o,
  output logic [2:0]      id_fun3_o,
  output logic [6:0]      id_fun7_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            run_en_q;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_head;

  // run_en_q keeps the request low while in reset and for the first cycle after.
  assign imem_req_o  = run_en_q && (state_q == RUN) &&
                       (fifo_count < CW'(DEPTH)) && !redirect_i;
  assign imem_addr_o = pc_q;

  assign fifo_push  = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
  assign fifo_pop   = id_valid_o && id_ready_i;
  assign fifo_wdata = '{pc: req_pc_q, instr: imem_rdata_i};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (redirect_i),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Data outputs read zero when nothing is buffered, so reset shows zeros.
  assign id_valid_o = !fifo_empty;
  assign id_pc_o    = fifo_empty ? '0 : fifo_head.pc;
  assign id_instr_o = fifo_empty ? '0 : fifo_head.instr;
  assign id_op_o    = id_instr_o[6:0];
  assign id_fun3_o  = id_instr_o[14:12];
  assign id_fun7_o  = id_instr_o[31:25];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~XLEN'(3);
      // A response arriving with the redirect retires the outstanding read,
      // so there is nothing left to kill.
      unique case (state_q)
        WAIT:    state_d = imem_rvalid_i ? RUN : KILL;
        KILL:    state_d = imem_rvalid_i ? RUN : KILL;
        default: state_d = RUN;
      endcase
    end else begin
      unique case (state_q)
        RUN: begin
          if (imem_req_o && imem_gnt_i) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = WAIT;
          end
        end
        WAIT:    if (imem_rvalid_i) state_d = RUN;
        KILL:    if (imem_rvalid_i) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      run_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      run_en_q <= 1'b1;
    end
  end

  // Issue gating plus a single outstanding read means a push never meets a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(fifo_push && fifo_full && !fifo_pop));

endmodule
